// File: rtl/sudoku_input_pkg.sv
// Shared definitions for the sudoku button front end: button indices,
// raw polarity mask, channel state encoding and counter sizing.
package sudoku_input_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_START = 4;
  localparam int BTN_A     = 5;
  localparam int BTN_B     = 6;
  localparam int NUM_BTN   = 7;

  // Direction pad is wired active-low, start/a/b are active-high.
  localparam logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = 7'b0001111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } btn_state_e;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, debounce FSM with saturating
// counter, and direction-pad auto-repeat when built with BUTTON_REPEAT_EN.
//
// state     | meaning
// ----------|-----------------------------------------------
// IDLE      | released, waiting for the synced level to go active
// DEB_PRESS | level active, counting stable samples before accepting press
// HELD      | press accepted; held=1, auto-repeat runs here
// DEB_REL   | level inactive, counting stable samples before release; held=1
module button_debounce
  import sudoku_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter bit REPEAT_CAPABLE  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic press_o,
  output logic held_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic sync1_q, sync2_q;
  logic level;
  btn_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic press_q, press_d;
  logic deb_pulse, rep_pulse;

  // Synchroniser resets to the idle raw level so reset release is silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign level   = sync2_q ^ ACTIVE_LOW;
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    deb_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (level) begin
          if (ONE >= DEB_TC) begin
            state_d   = HELD;
            deb_pulse = 1'b1;
          end else begin
            state_d = DEB_PRESS;
            cnt_d   = ONE;
          end
        end
      end
      DEB_PRESS: begin
        if (!level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= DEB_TC) begin
          state_d   = HELD;
          cnt_d     = '0;
          deb_pulse = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!level) begin
          if (ONE >= DEB_TC) begin
            state_d = IDLE;
          end else begin
            state_d = DEB_REL;
            cnt_d   = ONE;
          end
        end
      end
      DEB_REL: begin
        if (level) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc >= DEB_TC) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  if (REPEAT_CAPABLE) begin : g_rep
`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(REPEAT_PERIOD);
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic rep_first_q, rep_first_d;

    assign rep_inc = (rep_cnt_q == CNT_SAT) ? rep_cnt_q : rep_cnt_q + ONE;

    // Counts only while staying in HELD; any exit rearms the initial delay.
    always_comb begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
      rep_pulse   = 1'b0;
      if (state_q == HELD && state_d == HELD) begin
        rep_first_d = rep_first_q;
        if (rep_inc >= (rep_first_q ? DELAY_TC : PERIOD_TC)) begin
          rep_pulse   = 1'b1;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = rep_inc;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b1;
      end else begin
        rep_cnt_q   <= rep_cnt_d;
        rep_first_q <= rep_first_d;
      end
    end
`else
    assign rep_pulse = 1'b0;
`endif
  end else begin : g_no_rep
    assign rep_pulse = 1'b0;
  end

  assign press_d = deb_pulse | rep_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;
  assign held_o  = (state_q == HELD) || (state_q == DEB_REL);

endmodule

// File: rtl/button_conditioner.sv
// Seven-button input front end for the sudoku game controller.
// Define BUTTON_REPEAT_EN to enable auto-repeat on the direction pad.
module button_conditioner
  import sudoku_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       original_up_button,
  input  logic       original_down_button,
  input  logic       original_left_button,
  input  logic       original_right_button,
  input  logic       original_start_button,
  input  logic       original_a_button,
  input  logic       original_b_button,
  output logic [6:0] press,
  output logic [6:0] held
);

  logic [NUM_BTN-1:0] raw;

  assign raw = {original_b_button, original_a_button, original_start_button,
                original_right_button, original_left_button,
                original_down_button, original_up_button};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .ACTIVE_LOW     (ACTIVE_LOW_MASK[i]),
      .REPEAT_CAPABLE (i <= BTN_RIGHT)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (raw[i]),
      .press_o(press[i]),
      .held_o (held[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner; expectations follow BUTTON_REPEAT_EN.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic up_b = 1'b1, down_b = 1'b1, left_b = 1'b1, right_b = 1'b1;
  logic start_b = 1'b0, a_b = 1'b0, b_b = 1'b0;
  logic [6:0] press, held;

  int n_checks = 0;
  int n_pass = 0;
  int ecnt = 0;

  typedef struct {
    int         cyc;
    logic [6:0] bits;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .original_up_button   (up_b),
    .original_down_button (down_b),
    .original_left_button (left_b),
    .original_right_button(right_b),
    .original_start_button(start_b),
    .original_a_button    (a_b),
    .original_b_button    (b_b),
    .press                (press),
    .held                 (held)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecnt);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // E0 is the first edge sampling the new raw level; pulse lands after E0+5.
  task automatic expect_press(input int e0, input logic [6:0] bits);
    exp_t e;
    e.cyc  = e0 + 5;
    e.bits = bits;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (press != 7'b0) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_press", {25'b0, press}, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("press_edge", ecnt, e.cyc);
        chk("press_bits", {25'b0, press}, {25'b0, e.bits});
      end
    end
  end

  initial begin
    int e0;
    int m;

    // reset with all buttons idle
    @(negedge clk);
    chk("reset_press", {25'b0, press}, 32'h0);
    chk("reset_held", {25'b0, held}, 32'h0);
    cycles(4);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_after_reset", {18'b0, press, held}, 32'h0);
    end

    // start held: one pulse, held rises on the same edge
    start_b = 1'b1;
    e0 = ecnt + 1;
    expect_press(e0, 7'b0010000);
    cycles(5);
    chk("start_held_early", {31'b0, held[4]}, 32'h0);
    cycles(1);
    chk("start_held_rise", {31'b0, held[4]}, 32'h1);
    cycles(40);
    chk("start_held_stay", {31'b0, held[4]}, 32'h1);
    start_b = 1'b0;
    cycles(5);
    chk("start_held_release_early", {31'b0, held[4]}, 32'h1);
    cycles(1);
    chk("start_held_release", {31'b0, held[4]}, 32'h0);
    cycles(4);

    // a: 3-cycle bounce then zero-width glitch
    a_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("a_short_held", {31'b0, held[5]}, 32'h0);
    end
    a_b = 1'b0;
    a_b = 1'b1;
    a_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("a_short_held", {31'b0, held[5]}, 32'h0);
    end

    // up held 60 cycles
    up_b = 1'b0;
    e0 = ecnt + 1;
    expect_press(e0, 7'b0000001);
`ifdef BUTTON_REPEAT_EN
    expect_press(e0 + 20, 7'b0000001);
    expect_press(e0 + 28, 7'b0000001);
    expect_press(e0 + 36, 7'b0000001);
    expect_press(e0 + 44, 7'b0000001);
    expect_press(e0 + 52, 7'b0000001);
`endif
    cycles(60);
    chk("up_held", {31'b0, held[0]}, 32'h1);
    up_b = 1'b1;
    cycles(10);
    chk("up_released", {31'b0, held[0]}, 32'h0);
    chk("sb_drained_up", sb_q.size(), 32'h0);

    // down + right together, then a 2-cycle release glitch on down
    down_b  = 1'b0;
    right_b = 1'b0;
    e0 = ecnt + 1;
    expect_press(e0, 7'b0001010);
    cycles(7);
    chk("down_held", {31'b0, held[1]}, 32'h1);
    chk("right_held", {31'b0, held[3]}, 32'h1);
    down_b = 1'b1;
    cycles(2);
    down_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("down_glitch_held", {31'b0, held[1]}, 32'h1);
    end
    down_b  = 1'b1;
    right_b = 1'b1;
    cycles(10);
    chk("down_right_released", {30'b0, held[3], held[1]}, 32'h0);

    // b held through a reset pulse
    b_b = 1'b1;
    e0 = ecnt + 1;
    expect_press(e0, 7'b1000000);
    cycles(8);
    chk("b_held", {31'b0, held[6]}, 32'h1);
    reset = 1'b1;
    m = ecnt;
    @(negedge clk);
    chk("b_reset_held", {25'b0, held}, 32'h0);
    chk("b_reset_press", {25'b0, press}, 32'h0);
    reset = 1'b0;
    expect_press(m + 2, 7'b1000000);
    cycles(5);
    chk("b_rearm_early", {31'b0, held[6]}, 32'h0);
    cycles(1);
    chk("b_rearm_held", {31'b0, held[6]}, 32'h1);
    b_b = 1'b0;
    cycles(10);
    chk("b_released", {31'b0, held[6]}, 32'h0);

    cycles(5);
    chk("sb_drained_end", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input front end of the sudoku `top`. It receives the seven raw board buttons (`original_*_button`) and delivers clean, single-cycle press pulses and held levels to the game FSM. Per button, it handles polarity normalisation, 2-flop synchronisation, debouncing and, optionally, auto-repeat on the direction pad. It sits between the top-level pins and the game controller and is the consuming end of the button stimulus driven at `top`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable samples required to accept a level change. Must be ≥1.
- `REPEAT_DELAY`, default 25000000: cycles from the first press pulse to the first auto-repeat pulse.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent auto-repeat pulses.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `original_up_button`  in  1  raw, active-low (idle 1).
- `original_down_button`  in  1  raw, active-low.
- `original_left_button`  in  1  raw, active-low.
- `original_right_button`  in  1  raw, active-low.
- `original_start_button`  in  1  raw, active-high (idle 0).
- `original_a_button`  in  1  raw, active-high.
- `original_b_button`  in  1  raw, active-high.
- `press`  out  7  one-cycle press pulses. Bit index: 0 up, 1 down, 2 left, 3 right, 4 start, 5 a, 6 b.
- `held`  out  7  debounced pressed level, same bit index.

## Operation
- Normalisation: raw inputs are XORed with `ACTIVE_LOW_MASK` = 7'b0001111, so internal level 1 = pressed.
- Each channel has a 2-flop synchroniser followed by a 4-state FSM:
  - IDLE → DEB_PRESS when the synced level is 1. The counter loads 1.
  - DEB_PRESS: the counter increments while the level is 1. If the level returns to 0 before the count is reached: back to IDLE, counter cleared, no pulse. When the count reaches `DEBOUNCE_CYCLES`: go to HELD and assert `press` for one cycle.
  - HELD → DEB_REL when the level is 0. The counter loads 1.
  - DEB_REL: the counter increments while the level is 0. If the level returns to 1: back to HELD with no new pulse. When the count reaches `DEBOUNCE_CYCLES`: go to IDLE.
- `held` = 1 in HELD and DEB_REL.
- Channels are fully independent. Several `press` bits may assert in the same cycle.
- Pulses of zero or sub-cycle width (press and release in the same timestep) are never seen and produce nothing.
- Counter width is `$clog2` of max(`DEBOUNCE_CYCLES`, `REPEAT_DELAY`, `REPEAT_PERIOD`) + 1. Counters saturate and never wrap.

## Timing
- Reset values: `press` = 0, `held` = 0, all FSMs in IDLE, counters 0. Synchroniser flops load the *inactive* raw level (1 for bits 0–3, 0 for bits 4–6), so reset release never creates a spurious press.
- Press latency: if the raw level is active and stable from rising edge E0, `press` is high exactly in the cycle after edge E0+1+`DEBOUNCE_CYCLES`. `held` rises on that same edge.
- Release latency: if the raw level is inactive and stable from edge R0, `held` falls on edge R0+1+`DEBOUNCE_CYCLES`.
- Reset asserted mid-operation: on the next edge all outputs are 0 and all channels are IDLE. A button held through reset deassertion produces a fresh press after the full debounce latency.

## Configuration
- `BUTTON_REPEAT_EN` defined: for bits 0–3 only, while in HELD, extra `press` pulses occur at `REPEAT_DELAY` cycles after the first pulse, then every `REPEAT_PERIOD` cycles. Repeat stops on entry to DEB_REL and restarts from `REPEAT_DELAY` on the next press. Bits 4–6 never repeat.
- `BUTTON_REPEAT_EN` undefined: exactly one pulse per press on every bit. The repeat counter logic is not synthesised.

## Structure
- Package `sudoku_input_pkg` holds:
  - button index constants (`BTN_UP` … `BTN_B`);
  - `ACTIVE_LOW_MASK`;
  - the channel state enum (IDLE, DEB_PRESS, HELD, DEB_REL).
- Sub-module `button_debounce` implements one channel: synchroniser, FSM, counter and optional repeat, with parameters `ACTIVE_LOW`, `REPEAT_CAPABLE`. `button_conditioner` instantiates it seven times.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
- Reset held 5 cycles with all buttons idle, then released → `press` = 0 and `held` = 0 for 50 cycles.
- `original_start_button` raised at E0 and held → `press[4]` high only in the cycle after E5. `held[4]` = 1 from E5.
- `original_a_button` pulsed high for 3 cycles, and separately for 0 time → no `press[5]`. `held[5]` stays 0.
- `original_up_button` driven low and held 60 cycles with `BUTTON_REPEAT_EN` → `press[0]` pulses after E5, E25, E33, E41, E49, E57. Without the macro → only after E5.
- Down and right pressed at the same edge → `press[1]` and `press[3]` assert in the same cycle. A 2-cycle release glitch on down while held → no second pulse, and `held[1]` stays 1.
- Reset asserted while `b` is held in HELD, then deasserted with `b` still pressed → `held[6]` = 0 on the next edge, then a new `press[6]` after 1+4 further edges.
